// File: rtl/pong_sound_pkg.sv
// Shared types and helpers for the Pong sound engine: FSM states, event
// selection and per-event field extraction from packed parameter vectors.
package pong_sound_pkg;

  localparam int MAX_EVENTS = 32;
  localparam int MAX_CNT_W  = 32;
  localparam int MAX_VEC    = MAX_EVENTS * MAX_CNT_W;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } sel_t;

  // Slice i of a vector packed in w-bit fields; callers truncate to their width.
  function automatic logic [MAX_CNT_W-1:0] field(input logic [MAX_VEC-1:0] vec,
                                                 input int i, input int w);
    return MAX_CNT_W'(vec >> (i * w));
  endfunction

  function automatic sel_t lowest_set(input logic [MAX_EVENTS-1:0] mask);
    sel_t r;
    r = '0;
    for (int i = MAX_EVENTS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.valid = 1'b1;
        r.idx   = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sound_tone_gen.sv
// Square-wave generator: toggles its output every half_period cycles while
// running, restarts high on restart, and rests low otherwise.
module sound_tone_gen import pong_sound_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] half_period,
  input  logic             restart,
  input  logic             run,
  output logic             wave
);

  logic [CNT_W-1:0] hp_cnt;

  always_ff @(posedge clk) begin
    if (!reset || (!restart && !run)) begin
      hp_cnt <= '0;
      wave   <= 1'b0;
    end else if (restart) begin
      hp_cnt <= '0;
      wave   <= 1'b1;
    end else if (hp_cnt == half_period - CNT_W'(1)) begin
      hp_cnt <= '0;
      wave   <= ~wave;
    end else begin
      hp_cnt <= hp_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pong_sound_engine.sv
// Multi-event Pong buzzer: fixed-priority arbitration, one-deep pending slot,
// per-event pitch/duration and a silent gap between consecutive tones.
module pong_sound_engine import pong_sound_pkg::*; #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_W      = 16,
  parameter logic [NUM_EVENTS*CNT_W-1:0] HALF_PERIODS =
    {16'd24000, 16'd12000, 16'd6000, 16'd3000},
  parameter logic [NUM_EVENTS*CNT_W-1:0] DURATIONS =
    {16'd200, 16'd400, 16'd60, 16'd40},
  parameter int PRESCALE  = 12000,
  parameter int GAP_UNITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_EVENTS-1:0]         event_req,
  output logic                          buzzer,
  output logic                          busy,
  output logic [$clog2(NUM_EVENTS)-1:0] active_event,
  output logic                          dropped
);

  localparam int IDX_W = $clog2(NUM_EVENTS);
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_UNITS - 1);

  state_t                state, nxt_state;
  logic [IDX_W-1:0]      cur, nxt_cur, win, pend_idx;
  logic                  pend_valid, pend_keep;
  logic [PS_W-1:0]       presc;
  logic [CNT_W-1:0]      unit_cnt, cur_dur, cur_half;
  sel_t                  win_sel, new_pend;
  logic [NUM_EVENTS-1:0] win_oh, pend_oh, cand, merged;
  logic                  start, to_gap, do_next, preempt, drop;
  logic                  wrap, play_done, gap_done;

  assign win_sel  = lowest_set(MAX_EVENTS'(event_req));
  assign win      = IDX_W'(win_sel.idx);
  assign win_oh   = NUM_EVENTS'(1) << win;
  assign pend_oh  = pend_valid ? (NUM_EVENTS'(1) << pend_idx) : '0;
  assign cur_dur  = CNT_W'(field(MAX_VEC'(DURATIONS), int'(cur), CNT_W));
  assign cur_half = CNT_W'(field(MAX_VEC'(HALF_PERIODS), int'(cur), CNT_W));

  assign wrap      = (presc == PS_LAST);
  assign play_done = (state == PLAY) && wrap && (unit_cnt == cur_dur - CNT_W'(1));
  assign gap_done  = (state == GAP) && wrap && (unit_cnt == GAP_LAST);

  // Next state plus the set of requests competing for the pending slot (cand).
  always_comb begin
    nxt_state = state;
    nxt_cur   = cur;
    start     = 1'b0;
    to_gap    = 1'b0;
    do_next   = 1'b0;
    preempt   = 1'b0;
    pend_keep = pend_valid;
    cand      = '0;
    case (state)
      IDLE: begin
        if (win_sel.valid) begin
          nxt_state = PLAY;
          nxt_cur   = win;
          start     = 1'b1;
          cand      = event_req & ~win_oh;
        end
      end
      PLAY: begin
        if (win_sel.valid && win <= cur) begin
          preempt = (win < cur);
          nxt_cur = win;
          start   = 1'b1;
          cand    = event_req & ~win_oh;
        end else begin
          cand = event_req;
          if (play_done) begin
            if (GAP_UNITS > 0) begin
              nxt_state = GAP;
              to_gap    = 1'b1;
            end else begin
              do_next = 1'b1;
            end
          end
        end
      end
      GAP: begin
        cand    = event_req;
        do_next = gap_done;
      end
      default: nxt_state = IDLE;
    endcase

    if (do_next) begin
      if (pend_valid) begin
        nxt_state = PLAY;
        nxt_cur   = pend_idx;
        start     = 1'b1;
        pend_keep = 1'b0;
        cand      = event_req;
      end else if (win_sel.valid) begin
        nxt_state = PLAY;
        nxt_cur   = win;
        start     = 1'b1;
        cand      = event_req & ~win_oh;
      end else begin
        nxt_state = IDLE;
        cand      = '0;
      end
    end
  end

  // The slot keeps the best of itself and the candidates; any loser is dropped.
  assign merged   = cand | (pend_keep ? pend_oh : '0);
  assign new_pend = lowest_set(MAX_EVENTS'(merged));
  assign drop     = preempt
                  || ((merged & (merged - NUM_EVENTS'(1))) != '0)
                  || (pend_keep && ((cand & pend_oh) != '0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cur        <= '0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      presc      <= '0;
      unit_cnt   <= '0;
      dropped    <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      presc      <= '0;
      unit_cnt   <= '0;
      dropped    <= 1'b0;
    end else begin
      state      <= nxt_state;
      cur        <= nxt_cur;
      pend_valid <= new_pend.valid;
      pend_idx   <= IDX_W'(new_pend.idx);
      dropped    <= drop;
      if (start || to_gap || nxt_state == IDLE) begin
        presc    <= '0;
        unit_cnt <= '0;
      end else begin
        presc <= wrap ? '0 : presc + PS_W'(1);
        if (wrap) unit_cnt <= unit_cnt + CNT_W'(1);
      end
    end
  end

  assign busy         = (state == PLAY);
  assign active_event = cur;

  sound_tone_gen #(.CNT_W(CNT_W)) u_tone (
    .clk         (clk),
    .reset       (reset),
    .half_period (cur_half),
    .restart     (enable && start),
    .run         (enable && !start && nxt_state == PLAY),
    .wave        (buzzer)
  );

endmodule

// File: tb/tb_pong_sound_engine.sv
// Directed bench for pong_sound_engine: a vector table for the plain tone
// sequences, hand-written sequences for preemption, retrigger, mute and reset.
module tb_pong_sound_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] event_req;
  logic       buzzer, busy, dropped;
  logic [1:0] active_event;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] req;
    logic       buz;
    logic       bsy;
    logic [1:0] act;
    logic       drp;
  } vec_t;

  vec_t vecs[$];

  pong_sound_engine #(
    .NUM_EVENTS   (3),
    .CNT_W        (16),
    .HALF_PERIODS ({16'd3, 16'd2, 16'd1}),
    .DURATIONS    ({16'd2, 16'd3, 16'd2}),
    .PRESCALE     (4),
    .GAP_UNITS    (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .event_req    (event_req),
    .buzzer       (buzzer),
    .busy         (busy),
    .active_event (active_event),
    .dropped      (dropped)
  );

  always #5 clk = ~clk;

  // Expected square-wave level at play cycle k of event e.
  function automatic logic tone(input int e, input int k);
    int hp;
    hp = (e == 0) ? 1 : (e == 1) ? 2 : 3;
    return ((k / hp) % 2) == 0;
  endfunction

  task automatic addVec(input logic [2:0] req, input logic buz, input logic bsy,
                        input logic [1:0] act, input logic drp);
    vec_t v;
    v.req = req; v.buz = buz; v.bsy = bsy; v.act = act; v.drp = drp;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [2:0] req);
    event_req = req;
    @(posedge clk);
    #1;
    event_req = '0;
  endtask

  task automatic checkOutput(input string name, input logic buz, input logic bsy,
                             input logic [1:0] act, input logic drp);
    checks++;
    if (buzzer !== buz || busy !== bsy || active_event !== act || dropped !== drp) begin
      failures++;
      $display("[TB] FAIL %s: got buzzer=%b busy=%b active=%0d dropped=%b, expected buzzer=%b busy=%b active=%0d dropped=%b",
               name, buzzer, busy, active_event, dropped, buz, bsy, act, drp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Request e1, retrigger it after `at` play cycles, and measure the busy span.
  task automatic retrigSeq(input string name, input int at, input int exp_len);
    int k;
    int len;
    k   = 0;
    len = 0;
    applyStimulus(3'b010);
    for (int c = 0; c < 60; c++) begin
      if (busy !== 1'b1) break;
      checkOutput($sformatf("%s_c%0d", name, c), tone(1, k), 1'b1, 2'd1, 1'b0);
      len++;
      if (c == at - 1) begin
        applyStimulus(3'b010);
        k = 0;
      end else begin
        applyStimulus(3'b000);
        k++;
      end
    end
    checkValue({name, "_len"}, len, exp_len);
    repeat (4) applyStimulus(3'b000);
    checkOutput({name, "_idle"}, 1'b0, 1'b0, 2'd1, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    event_req = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;

    // Simultaneous requests: e0 plays, e1 waits in the slot, e2 is dropped.
    addVec(3'b111, 1'b1, 1'b1, 2'd0, 1'b1);
    for (int k = 1; k < 8; k++) addVec(3'b000, tone(0, k), 1'b1, 2'd0, 1'b0);
    repeat (4) addVec(3'b000, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 12; k++) addVec(3'b000, tone(1, k), 1'b1, 2'd1, 1'b0);
    repeat (5) addVec(3'b000, 1'b0, 1'b0, 2'd1, 1'b0);
    // Single event e1 from idle.
    addVec(3'b010, 1'b1, 1'b1, 2'd1, 1'b0);
    for (int k = 1; k < 12; k++) addVec(3'b000, tone(1, k), 1'b1, 2'd1, 1'b0);
    repeat (5) addVec(3'b000, 1'b0, 1'b0, 2'd1, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req);
      checkOutput($sformatf("vec%0d", i), vecs[i].buz, vecs[i].bsy, vecs[i].act, vecs[i].drp);
    end

    // Preemption: e0 interrupts e2 during its fourth play cycle.
    applyStimulus(3'b100);
    checkOutput("pre_e2_c0", 1'b1, 1'b1, 2'd2, 1'b0);
    for (int k = 1; k < 3; k++) begin
      applyStimulus(3'b000);
      checkOutput($sformatf("pre_e2_c%0d", k), tone(2, k), 1'b1, 2'd2, 1'b0);
    end
    applyStimulus(3'b001);
    checkOutput("pre_switch", 1'b1, 1'b1, 2'd0, 1'b1);
    for (int k = 1; k < 8; k++) begin
      applyStimulus(3'b000);
      checkOutput($sformatf("pre_e0_c%0d", k), tone(0, k), 1'b1, 2'd0, 1'b0);
    end
    for (int k = 0; k < 10; k++) begin
      applyStimulus(3'b000);
      checkOutput($sformatf("pre_quiet%0d", k), 1'b0, 1'b0, 2'd0, 1'b0);
    end

    retrigSeq("retrig8", 8, 20);
    retrigSeq("retrig5", 5, 17);

    // Mute mid-tone with e2 pending: nothing may play afterwards.
    applyStimulus(3'b001);
    checkOutput("mute_play", 1'b1, 1'b1, 2'd0, 1'b0);
    applyStimulus(3'b100);
    checkOutput("mute_pend", tone(0, 1), 1'b1, 2'd0, 1'b0);
    enable = 1'b0;
    applyStimulus(3'b000);
    checkOutput("mute_off", 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(3'b001);
    checkOutput("mute_ignored", 1'b0, 1'b0, 2'd0, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(3'b000);
      checkOutput($sformatf("mute_after%0d", k), 1'b0, 1'b0, 2'd0, 1'b0);
    end

    // Reset during the gap while e2 sits in the pending slot.
    applyStimulus(3'b010);
    checkOutput("rst_play", 1'b1, 1'b1, 2'd1, 1'b0);
    applyStimulus(3'b100);
    checkOutput("rst_pend", tone(1, 1), 1'b1, 2'd1, 1'b0);
    for (int k = 2; k < 12; k++) applyStimulus(3'b000);
    applyStimulus(3'b000);
    checkOutput("rst_gap", 1'b0, 1'b0, 2'd1, 1'b0);
    applyStimulus(3'b000);
    reset = 1'b0;
    applyStimulus(3'b000);
    checkOutput("rst_mid_gap", 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(3'b000);
      checkOutput($sformatf("rst_after%0d", k), 1'b0, 1'b0, 2'd0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
